// File: rtl/zxn_ram_arbiter_if.sv
// zxn_ram_arbiter_if: core, loader and BRAM signal bundle around the main RAM arbiter
interface zxn_ram_arbiter_if #(parameter int ADDR_W = 19);
  logic [20:0] core_addr;
  logic [7:0] core_din;
  logic [7:0] core_dout;
  logic core_cs;
  logic core_we;
  logic core_rd;
  logic core_wait;
  logic ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0] ld_data;
  logic ld_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_din;
  logic mem_we;
  logic [7:0] mem_dout;
  modport slave (
    input core_addr, core_din, core_cs, core_we, core_rd, ld_wr, ld_addr, ld_data, mem_dout,
    output core_dout, core_wait, ld_wait, mem_addr, mem_din, mem_we
  );
  modport master (
    output core_addr, core_din, core_cs, core_we, core_rd, ld_wr, ld_addr, ld_data, mem_dout,
    input core_dout, core_wait, ld_wait, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/zxn_ram_arbiter.sv
// zxn_ram_arbiter: shares the main RAM port between fill engine, HPS loader and core; loader port built only with ZXN_ARB_LOADER_EN
module zxn_ram_arbiter #(
  parameter int MEM_SIZE = 409600,
  parameter int ADDR_W = 19,
  parameter logic [7:0] FILL = 8'hFF,
  parameter int STARVE = 8
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic clr_req,
  output logic busy,
  zxn_ram_arbiter_if.slave bus
);
  localparam logic [31:0] MS = 32'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);
  typedef enum logic [1:0] {HOLD, FILLING, RUN} state_t;
  state_t state_q, st, nxt;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] ld_addr_r;
  logic [7:0] ld_data_r;
  logic ld_go, ld_oor, core_oor, rd_ok, rd_ok_q;
  assign st = RESET ? HOLD : state_q;
  assign core_oor = 32'(bus.core_addr) >= MS;
  // state register; RESET is decoded straight into HOLD, so the first fill write lands in the first cycle after release
  always_ff @(posedge clk_sys) state_q <= RESET ? FILLING : nxt;
  // next state: fill until the last location, any clear restarts the fill
  always_comb nxt = (st == HOLD || clr_req || (st == FILLING && cnt_q != LAST)) ? FILLING : RUN;
  // fill address counter, rewound by reset or clear
  always_ff @(posedge clk_sys) cnt_q <= (RESET || clr_req || st != FILLING) ? '0 : cnt_q + 1'b1;
  // port mux: fill engine first, then a pending loader write, otherwise the core
  always_comb begin
    busy = st != RUN;
    bus.mem_addr = st == FILLING ? cnt_q : ld_go ? ld_addr_r : bus.core_addr[ADDR_W-1:0];
    bus.mem_din = st == FILLING ? FILL : ld_go ? ld_data_r : bus.core_din;
    bus.mem_we = st == FILLING || (ld_go ? !ld_oor : st == RUN && bus.core_cs && bus.core_we && !core_oor);
    bus.core_wait = bus.core_cs && (st == FILLING || ld_go);
    rd_ok = st == RUN && !ld_go && bus.core_cs && bus.core_rd && !core_oor;
  end
  // remembers whether BRAM data next cycle belongs to a granted in-range core read
  always_ff @(posedge clk_sys) rd_ok_q <= rd_ok;
  assign bus.core_dout = rd_ok_q && !RESET ? bus.mem_dout : FILL;
`ifdef ZXN_ARB_LOADER_EN
  localparam int SW = $clog2(STARVE + 1);
  logic pend_q;
  logic [SW-1:0] starve_q;
  assign ld_go = st == RUN && pend_q && (!bus.core_cs || starve_q == SW'(STARVE - 1));
  assign ld_oor = 32'(ld_addr_r) >= MS;
  assign bus.ld_wait = pend_q && !RESET;
  // pending flag: set by a loader write, held through fill, cleared when the write issues
  always_ff @(posedge clk_sys) pend_q <= (RESET || ld_go) ? 1'b0 : pend_q || bus.ld_wr;
  // loader address/data capture; writes arriving while one is pending are dropped
  always_ff @(posedge clk_sys) if (bus.ld_wr && !pend_q) begin
    ld_addr_r <= bus.ld_addr;
    ld_data_r <= bus.ld_data;
  end
  // cycles the pending write has lost to the core; at STARVE-1 the loader steals the slot
  always_ff @(posedge clk_sys) starve_q <= (RESET || ld_go) ? '0 : starve_q + SW'(pend_q && st == RUN && bus.core_cs);
`else
  localparam int unused_starve = STARVE;
  logic unused_ld;
  assign ld_go = 1'b0;
  assign ld_oor = 1'b1;
  assign ld_addr_r = '0;
  assign ld_data_r = '0;
  assign bus.ld_wait = 1'b0;
  assign unused_ld = ^{bus.ld_wr, bus.ld_addr, bus.ld_data};
`endif
endmodule

// File: tb/tb_zxn_ram_arbiter.sv
// tb_zxn_ram_arbiter: directed checks of fill, loader, starvation, range and clear behaviour
module tb_zxn_ram_arbiter;
  localparam int MS = 16;
  localparam int AW = 5;
  localparam int ST = 8;
`ifdef ZXN_ARB_LOADER_EN
  localparam bit LD = 1'b1;
`else
  localparam bit LD = 1'b0;
`endif
  logic clk_sys = 1'b0;
  logic RESET = 1'b1;
  logic clr_req = 1'b0;
  logic busy;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] ram [0:31];
  zxn_ram_arbiter_if #(.ADDR_W(AW)) bus ();
  zxn_ram_arbiter #(.MEM_SIZE(MS), .ADDR_W(AW), .FILL(8'hFF), .STARVE(ST)) dut (
    .clk_sys(clk_sys),
    .RESET(RESET),
    .clr_req(clr_req),
    .busy(busy),
    .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic smp();
    @(negedge clk_sys);
  endtask
  task automatic core(input logic cs, input logic we, input logic rd, input logic [20:0] a, input logic [7:0] d);
    bus.core_cs = cs;
    bus.core_we = we;
    bus.core_rd = rd;
    bus.core_addr = a;
    bus.core_din = d;
  endtask
  task automatic ld(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    bus.ld_wr = wr;
    bus.ld_addr = a;
    bus.ld_data = d;
  endtask
  initial begin
    core(0, 0, 0, 0, 0);
    ld(0, 0, 0);
    tick();
    tick();
    smp();
    chk("reset_flags", {busy, bus.mem_we, bus.core_wait, bus.ld_wait}, 4'b1000);
    chk("reset_dout", bus.core_dout, 8'hFF);
    tick();
    RESET = 1'b0;
    core(1, 0, 1, 5, 0);
    for (int i = 0; i < MS; i++) begin
      smp();
      chk("fill", {bus.mem_we, bus.mem_addr, bus.mem_din, busy, bus.core_wait}, {1'b1, 5'(i), 8'hFF, 2'b11});
      tick();
    end
    smp();
    chk("run_entry", {busy, bus.mem_we, bus.mem_addr, bus.core_wait}, {1'b0, 1'b0, 5'd5, 1'b0});
    tick();
    core(0, 0, 0, 0, 0);
    smp();
    chk("rd5", bus.core_dout, 8'hFF);
    tick();
    core(0, 0, 0, 3, 8'h5A);
    ld(1, 3, 8'h5A);
    smp();
    chk("ld_idle_c0", {bus.mem_we, bus.ld_wait}, 2'b00);
    tick();
    ld(0, 0, 0);
    smp();
    chk("ld_idle_c1", {bus.mem_we, bus.mem_addr, bus.mem_din, bus.ld_wait}, {LD, 5'd3, 8'h5A, LD});
    tick();
    core(1, 0, 1, 3, 0);
    smp();
    chk("ld_wait_fall", {bus.ld_wait, bus.mem_we, bus.mem_addr}, {1'b0, 1'b0, 5'd3});
    tick();
    core(0, 0, 0, 0, 0);
    smp();
    chk("rd3", bus.core_dout, LD ? 8'h5A : 8'hFF);
    tick();
    core(1, 0, 1, 3, 0);
    ld(1, 7, 8'hC3);
    smp();
    chk("starve_c0", {bus.mem_we, bus.core_wait}, 2'b00);
    tick();
    ld(0, 0, 0);
    for (int k = 1; k < ST; k++) begin
      smp();
      chk("starve_hold", {bus.mem_we, bus.mem_addr, bus.core_wait, bus.ld_wait}, {1'b0, 5'd3, 1'b0, LD});
      tick();
    end
    smp();
    chk("starve_issue", {bus.mem_we, bus.mem_addr, bus.mem_din, bus.core_wait, bus.ld_wait}, {LD, LD ? 5'd7 : 5'd3, LD ? 8'hC3 : 8'h00, LD, LD});
    tick();
    smp();
    chk("starve_after", {bus.mem_we, bus.mem_addr, bus.core_wait, bus.ld_wait, bus.core_dout}, {1'b0, 5'd3, 1'b0, 1'b0, 8'hFF});
    tick();
    core(0, 0, 0, 0, 0);
    smp();
    chk("starve_rd_done", bus.core_dout, LD ? 8'h5A : 8'hFF);
    tick();
    core(1, 0, 1, 7, 0);
    tick();
    core(0, 0, 0, 0, 0);
    smp();
    chk("rd7", bus.core_dout, LD ? 8'hC3 : 8'hFF);
    tick();
    core(1, 1, 0, 16, 8'h11);
    smp();
    chk("oor_wr", bus.mem_we, 1'b0);
    tick();
    core(1, 1, 0, 9, 8'h99);
    smp();
    chk("wr9", {bus.mem_we, bus.mem_addr, bus.mem_din}, {1'b1, 5'd9, 8'h99});
    tick();
    core(1, 1, 0, 21'h100009, 8'h77);
    smp();
    chk("hi_wr", bus.mem_we, 1'b0);
    tick();
    core(1, 0, 1, 17, 0);
    tick();
    core(1, 0, 1, 21'h100009, 0);
    smp();
    chk("oor_rd", bus.core_dout, 8'hFF);
    tick();
    core(1, 0, 1, 9, 0);
    smp();
    chk("hi_rd", bus.core_dout, 8'hFF);
    tick();
    core(0, 0, 0, 0, 0);
    smp();
    chk("rd9", bus.core_dout, 8'h99);
    tick();
    clr_req = 1'b1;
    smp();
    chk("clr_run", busy, 1'b0);
    tick();
    clr_req = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) clr_req = 1'b1;
      smp();
      chk("clr_fill1", {busy, bus.mem_we, bus.mem_addr, bus.mem_din}, {1'b1, 1'b1, 5'(i), 8'hFF});
      tick();
      clr_req = 1'b0;
    end
    for (int i = 0; i < MS; i++) begin
      if (i == 3) ld(1, 2, 8'h33);
      if (i == MS - 1) clr_req = 1'b1;
      smp();
      chk("clr_fill2", {busy, bus.mem_we, bus.mem_addr, bus.mem_din, bus.ld_wait}, {1'b1, 1'b1, 5'(i), 8'hFF, 1'(LD && i > 3)});
      tick();
      ld(0, 0, 0);
      clr_req = 1'b0;
    end
    for (int i = 0; i < MS; i++) begin
      smp();
      chk("clr_fill3", {busy, bus.mem_we, bus.mem_addr, bus.ld_wait}, {1'b1, 1'b1, 5'(i), LD});
      tick();
    end
    smp();
    chk("ld_after_fill", {busy, bus.mem_we, bus.mem_addr, bus.mem_din}, {1'b0, LD, LD ? 5'd2 : 5'd0, LD ? 8'h33 : 8'h00});
    tick();
    core(1, 0, 1, 2, 0);
    tick();
    core(0, 0, 0, 0, 0);
    smp();
    chk("rd2", bus.core_dout, LD ? 8'h33 : 8'hFF);
    tick();
    core(1, 0, 1, 4, 0);
    ld(1, 4, 8'h44);
    tick();
    ld(0, 0, 0);
    RESET = 1'b1;
    smp();
    chk("reset_mid", {busy, bus.mem_we, bus.core_wait, bus.ld_wait, bus.core_dout}, {1'b1, 1'b0, 1'b0, 1'b0, 8'hFF});
    tick();
    RESET = 1'b0;
    core(0, 0, 0, 0, 0);
    smp();
    chk("refill_start", {busy, bus.mem_we, bus.mem_addr, bus.ld_wait}, {1'b1, 1'b1, 5'd0, 1'b0});
    repeat (MS) tick();
    smp();
    chk("discard", {busy, bus.mem_we, bus.ld_wait}, 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/zxn_ram_arbiter.md
# zxn_ram_arbiter

Single-port arbiter and sequencer for the core's on-chip main RAM (BRAM, 1-cycle registered read). It owns the physical memory port and shares it between three requesters: a fill engine that writes every location with a constant after reset or a clear request, an HPS download loader (ioctl-style byte writes), and the ZX Next core bus. Priority is fill > loader > core, with bounded loader latency under continuous core traffic.

## Interface
Parameters:
- MEM_SIZE, 409600: number of byte locations; addresses >= MEM_SIZE are out of range.
- ADDR_W, 19: physical address width; must satisfy 2^ADDR_W >= MEM_SIZE.
- FILL, 8'hFF: value written by the fill engine and returned for blocked or out-of-range reads.
- STARVE, 8: maximum cycles a pending loader write waits before it steals a slot.

Ports:
- clk_sys  in  1  system clock, 28 MHz.
- RESET  in  1  reset; synchronous, active-high; starts a fill when released.
- clr_req  in  1  one-cycle pulse; restarts the fill from address 0.
- busy  out  1  fill in progress; the core is held in reset from this.
- core_addr  in  21  core byte address.
- core_din  in  8  core write data.
- core_cs, core_we, core_rd  in  1 each  core chip select, write strobe, read strobe.
- core_dout  out  8  core read data.
- core_wait  out  1  the core access in this cycle was not performed; the core holds its request.
- ld_wr  in  1  loader write strobe, one cycle.
- ld_addr  in  ADDR_W  loader address.
- ld_data  in  8  loader data.
- ld_wait  out  1  loader write pending; no new ld_wr while high.
- mem_addr  out  ADDR_W  to BRAM.
- mem_din  out  8  to BRAM.
- mem_we  out  1  to BRAM.
- mem_dout  in  8  from BRAM; valid the cycle after mem_addr.

## Operation
- States: HOLD (RESET high), FILL, RUN.
- HOLD: mem_we=0, busy=1, fill counter=0, pending=0, starve=0. Next state is FILL.
- FILL: mem_addr=counter, mem_din=FILL, mem_we=1, and the counter increments each cycle. After writing MEM_SIZE-1 the block enters RUN. busy=1 throughout. core_wait=1 whenever core_cs=1.
- clr_req in any state except HOLD: the counter goes to 0 and the block enters or stays in FILL. A clr_req in the same cycle as the final fill write still restarts the fill.
- RUN, loader handling:
  - ld_wr with pending=0 latches addr/data into the pending register and sets pending.
  - ld_wr with pending=1 is dropped.
  - ld_wr during FILL is latched and held until RUN.
- RUN, slot allocation each cycle:
  - If pending and (core_cs=0 or starve=STARVE-1): loader write issues and pending clears. If core_cs=1 in that cycle, core_wait=1.
  - Otherwise the core gets the port: mem_addr=core_addr[ADDR_W-1:0], mem_din=core_din, mem_we=core_cs&core_we.
- Starve counter: increments while pending and the core holds the port; clears when the loader write issues.
- Out-of-range handling: a core or loader write with address >= MEM_SIZE drives mem_we=0 but still consumes its slot. A core read with address >= MEM_SIZE returns FILL. core_addr bits above ADDR_W must be 0; otherwise the access counts as out of range.
- core_dout is the registered mem_dout when the previous cycle was a granted in-range core read; otherwise it is FILL.
- ld_wait = pending (registered).

## Timing
- Reset values: busy=1, mem_we=0, core_wait=0, ld_wait=0, core_dout=FILL.
- The first fill write occurs in the first cycle after RESET falls. A full fill takes MEM_SIZE cycles, and busy falls in the cycle after the last write.
- Core path is combinational to mem_*: a read issued in cycle N has core_dout valid in cycle N+1 (one-cycle latency, same as direct BRAM).
- Loader latency, ld_wr to memory write:
  - idle core: 1 cycle;
  - worst case under continuous core_cs: STARVE cycles.
- ld_wait rises the cycle after ld_wr and falls the cycle after the write issues.
- RESET mid-fill or mid-load: an immediate return to HOLD. The pending write is discarded.

## Configuration
- ZXN_ARB_LOADER_EN defined: the loader port and starve logic are built as above.
- ZXN_ARB_LOADER_EN undefined: ld_wr is ignored, ld_wait is tied 0, no pending or starve registers exist, and core_wait is asserted only during FILL.

## Test plan
- RESET 1 cycle, MEM_SIZE=16 -> mem_we=1 for exactly 16 cycles at addresses 0..15 with data FF. busy falls in cycle 17; a read of address 5 returns FF.
- Idle core, ld_wr addr 3 data 5A -> mem_we at cycle+1 to address 3. ld_wait is high for 1 cycle; a core read of 3 returns 5A.
- core_cs held high with reads, ld_wr -> the loader write issues at cycle STARVE (8). core_wait=1 in exactly that cycle; the held core read then completes with correct data.
- clr_req at fill counter 10 -> the next write is to address 0 and busy stays high for MEM_SIZE more cycles.
- Core write address MEM_SIZE (out of range) -> mem_we=0. A core read of address MEM_SIZE+1 returns FF.
- ld_wr during FILL with addr 2 data 33 -> the fill completes, then address 2 is written with 33 in the first RUN cycle (core idle).
